// File: rtl/spi_frame_sequencer_if.sv
// Register-file side of the SPI frame sequencer: write/read strobes, address,
// write data and the read-data return path.
interface spi_frame_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [23:0]       reg_wdata;
  logic [23:0]       reg_rdata;
  logic              reg_rd_valid;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    input  reg_rdata, reg_rd_valid
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    output reg_rdata, reg_rd_valid
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Frame-level SPI slave controller: validates 32-bit frames, turns them into
// register-file writes/reads and loads the response word back into the shifter.
module spi_frame_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sclk_rise,
  input  logic                 ss_n_sync,
  input  logic [31:0]          rx_word,
  input  logic                 err_clear,
  spi_frame_sequencer_if.master reg_bus,
  output logic                 tx_load,
  output logic [31:0]          tx_word,
  output logic                 frame_error,
  output logic [15:0]          frame_count,
  output logic                 busy
);

  localparam int          RD_CNT_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [31:0] ERR_WORD   = 32'hDEAD_BEEF;
  localparam logic [5:0]  FRAME_BITS = 6'd32;
  localparam logic [5:0]  BIT_SAT    = 6'd33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE,
    ST_READ_WAIT,
    ST_LOAD
  } state_t;

  state_t state_reg, state_next;

  logic                ss_n_q_reg;
  logic [5:0]          bit_cnt_reg, bit_cnt_next;
  logic [RD_CNT_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic [5:0]          rd_tag_reg, rd_tag_next;
  logic [31:0]         resp_reg, resp_next;
  logic                resp_ok_reg, resp_ok_next;

  logic                tx_load_reg, tx_load_next;
  logic [31:0]         tx_word_reg, tx_word_next;
  logic                reg_wr_en_reg, reg_wr_en_next;
  logic                reg_rd_en_reg, reg_rd_en_next;
  logic [ADDR_W-1:0]   reg_addr_reg, reg_addr_next;
  logic [23:0]         reg_wdata_reg, reg_wdata_next;
  logic                frame_error_reg, frame_error_next;
  logic [15:0]         frame_count_reg, frame_count_next;
  logic                busy_reg, busy_next;

  logic                ss_fall;
  logic                ss_rise;
  logic                in_read_wait;
  logic                rd_hit;
  logic                rd_expired;
  logic                abort;
  logic                err_set;
  logic [ADDR_W-1:0]   rx_addr;

  // Only the low ADDR_W bits of the 6-bit address field reach the register file.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_addr
      assign rx_addr[gi] = rx_word[24 + gi];
    end
  endgenerate

  assign ss_fall      = ss_n_q_reg & ~ss_n_sync;
  assign ss_rise      = ~ss_n_q_reg & ss_n_sync;
  assign in_read_wait = (state_reg == ST_READ_WAIT);
  // The first READ_WAIT cycle is the strobe cycle itself; valid is only trusted after it.
  assign rd_hit       = in_read_wait && (rd_cnt_reg != '0) && reg_bus.reg_rd_valid;
  assign rd_expired   = in_read_wait && (rd_cnt_reg == RD_CNT_W'(RD_TIMEOUT));
  assign abort        = ss_fall && ((state_reg == ST_DECODE) ||
                                    (state_reg == ST_READ_WAIT) ||
                                    (state_reg == ST_LOAD));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ss_fall) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_rise) state_next = (bit_cnt_reg == FRAME_BITS) ? ST_DECODE : ST_IDLE;
      end
      ST_DECODE: begin
        if (ss_fall)                      state_next = ST_SHIFT;
        else if (rx_word[30] || rx_word[31]) state_next = ST_IDLE;
        else                              state_next = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (ss_fall)                     state_next = ST_SHIFT;
        else if (rd_hit || rd_expired)   state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ss_fall ? ST_SHIFT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    err_set          = 1'b0;
    tx_load_next     = 1'b0;
    tx_word_next     = tx_word_reg;
    reg_wr_en_next   = 1'b0;
    reg_rd_en_next   = 1'b0;
    reg_addr_next    = reg_addr_reg;
    reg_wdata_next   = reg_wdata_reg;
    frame_count_next = frame_count_reg;
    rd_cnt_next      = rd_cnt_reg;
    rd_tag_next      = rd_tag_reg;
    resp_next        = resp_reg;
    resp_ok_next     = resp_ok_reg;

    // A new select window always restarts the count, whatever was in flight.
    if (ss_fall) begin
      bit_cnt_next = '0;
    end else if (!ss_n_sync && sclk_rise && (bit_cnt_reg != BIT_SAT)) begin
      bit_cnt_next = bit_cnt_reg + 6'd1;
    end else begin
      bit_cnt_next = bit_cnt_reg;
    end

    case (state_reg)
      ST_SHIFT: begin
        if (ss_rise && (bit_cnt_reg != FRAME_BITS)) err_set = 1'b1;
      end
      ST_DECODE: begin
        if (!ss_fall) begin
          if (rx_word[30]) begin
            err_set      = 1'b1;
            tx_load_next = 1'b1;
            tx_word_next = ERR_WORD;
          end else if (rx_word[31]) begin
            reg_wr_en_next   = 1'b1;
            reg_addr_next    = rx_addr;
            reg_wdata_next   = rx_word[23:0];
            tx_load_next     = 1'b1;
            tx_word_next     = rx_word;
            frame_count_next = frame_count_reg + 16'd1;
          end else begin
            reg_rd_en_next = 1'b1;
            reg_addr_next  = rx_addr;
            rd_tag_next    = rx_word[29:24];
            rd_cnt_next    = '0;
          end
        end
      end
      ST_READ_WAIT: begin
        if (!ss_fall) begin
          rd_cnt_next = rd_cnt_reg + 1'b1;
          if (rd_hit) begin
            resp_next    = {2'b00, rd_tag_reg, reg_bus.reg_rdata};
            resp_ok_next = 1'b1;
          end else if (rd_expired) begin
            resp_next    = ERR_WORD;
            resp_ok_next = 1'b0;
            err_set      = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (!ss_fall) begin
          tx_load_next = 1'b1;
          tx_word_next = resp_reg;
          if (resp_ok_reg) frame_count_next = frame_count_reg + 16'd1;
        end
      end
      default: ;
    endcase

    if (abort) err_set = 1'b1;

    // Set has priority over clear so an error in the clearing cycle is never lost.
    frame_error_next = err_set | (frame_error_reg & ~err_clear);
    busy_next        = (state_next != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ss_n_q_reg      <= 1'b1;
      bit_cnt_reg     <= '0;
      rd_cnt_reg      <= '0;
      rd_tag_reg      <= '0;
      resp_reg        <= '0;
      resp_ok_reg     <= 1'b0;
      tx_load_reg     <= 1'b0;
      tx_word_reg     <= '0;
      reg_wr_en_reg   <= 1'b0;
      reg_rd_en_reg   <= 1'b0;
      reg_addr_reg    <= '0;
      reg_wdata_reg   <= '0;
      frame_error_reg <= 1'b0;
      frame_count_reg <= '0;
      busy_reg        <= 1'b0;
    end else begin
      ss_n_q_reg      <= ss_n_sync;
      bit_cnt_reg     <= bit_cnt_next;
      rd_cnt_reg      <= rd_cnt_next;
      rd_tag_reg      <= rd_tag_next;
      resp_reg        <= resp_next;
      resp_ok_reg     <= resp_ok_next;
      tx_load_reg     <= tx_load_next;
      tx_word_reg     <= tx_word_next;
      reg_wr_en_reg   <= reg_wr_en_next;
      reg_rd_en_reg   <= reg_rd_en_next;
      reg_addr_reg    <= reg_addr_next;
      reg_wdata_reg   <= reg_wdata_next;
      frame_error_reg <= frame_error_next;
      frame_count_reg <= frame_count_next;
      busy_reg        <= busy_next;
    end
  end

  assign tx_load           = tx_load_reg;
  assign tx_word           = tx_word_reg;
  assign frame_error       = frame_error_reg;
  assign frame_count       = frame_count_reg;
  assign busy              = busy_reg;
  assign reg_bus.reg_wr_en = reg_wr_en_reg;
  assign reg_bus.reg_rd_en = reg_rd_en_reg;
  assign reg_bus.reg_addr  = reg_addr_reg;
  assign reg_bus.reg_wdata = reg_wdata_reg;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Randomised frame traffic against an event-timeline reference model of the
// SPI frame sequencer; every access and response is checked with its cycle.
module tb_spi_frame_sequencer;

  localparam int ADDR_W     = 6;
  localparam int RD_TIMEOUT = 16;
  localparam int SETTLE     = RD_TIMEOUT + 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        sclk_rise;
  logic        ss_n_sync;
  logic [31:0] rx_word;
  logic        err_clear;
  logic        tx_load;
  logic [31:0] tx_word;
  logic        frame_error;
  logic [15:0] frame_count;
  logic        busy;

  always #5 clock = ~clock;

  spi_frame_sequencer_if #(.ADDR_W(ADDR_W)) reg_bus ();

  spi_frame_sequencer #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .sclk_rise   (sclk_rise),
    .ss_n_sync   (ss_n_sync),
    .rx_word     (rx_word),
    .err_clear   (err_clear),
    .reg_bus     (reg_bus),
    .tx_load     (tx_load),
    .tx_word     (tx_word),
    .frame_error (frame_error),
    .frame_count (frame_count),
    .busy        (busy)
  );

  typedef struct packed {
    int          cyc_n;
    logic [31:0] data;
  } ev_t;

  ev_t exp_tx[$], act_tx[$], exp_wr[$], act_wr[$], exp_rd[$], act_rd[$];

  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_err = 1'b0;
  int          rsp_lat = 0;
  logic [23:0] rsp_data = '0;
  int          valid_cyc = -1000;
  logic [31:0] prev_tx_word = '0;
  logic        rst_prev = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Register-file responder: one valid pulse rsp_lat cycles after each read strobe.
  initial begin
    reg_bus.reg_rd_valid = 1'b0;
    reg_bus.reg_rdata    = '0;
    forever begin
      @(posedge clock);
      #1;
      reg_bus.reg_rd_valid = (cyc == valid_cyc);
      reg_bus.reg_rdata    = (cyc == valid_cyc) ? rsp_data : 24'($urandom);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (tx_load) act_tx.push_back(ev_t'{cyc, tx_word});
      if (reg_bus.reg_wr_en)
        act_wr.push_back(ev_t'{cyc, {2'b00, 6'(reg_bus.reg_addr), reg_bus.reg_wdata}});
      if (reg_bus.reg_rd_en) begin
        act_rd.push_back(ev_t'{cyc, 32'(reg_bus.reg_addr)});
        if (rsp_lat != 0) valid_cyc = cyc + rsp_lat;
      end
      if (!rst_prev && (tx_word !== prev_tx_word)) check_val("tx_word_hold", tx_load, 1);
    end
    prev_tx_word = tx_word;
    rst_prev     = reset;
  end

  // Expected timeline of one frame whose ss_n rise was driven in cycle rise_cyc.
  task automatic predict(input logic [31:0] word, input int nbits, input int rise_cyc,
                         input int lat, input logic [23:0] rdata);
    int addr;
    int rd_cyc;
    addr   = int'(word[29:24]) % (1 << ADDR_W);
    rd_cyc = rise_cyc + 2;
    if (nbits != 32) begin
      exp_err = 1'b1;
    end else if (word[30]) begin
      exp_tx.push_back(ev_t'{rise_cyc + 2, 32'hDEADBEEF});
      exp_err = 1'b1;
    end else if (word[31]) begin
      exp_wr.push_back(ev_t'{rise_cyc + 2, 32'((addr << 24) | int'(word[23:0]))});
      exp_tx.push_back(ev_t'{rise_cyc + 2, word});
      exp_cnt = exp_cnt + 16'd1;
    end else begin
      exp_rd.push_back(ev_t'{rd_cyc, 32'(addr)});
      if (lat >= 1 && lat <= RD_TIMEOUT) begin
        exp_tx.push_back(ev_t'{rd_cyc + lat + 2, {2'b00, word[29:24], rdata}});
        exp_cnt = exp_cnt + 16'd1;
      end else begin
        exp_tx.push_back(ev_t'{rd_cyc + RD_TIMEOUT + 2, 32'hDEADBEEF});
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("tx_load_count", act_tx.size(), exp_tx.size());
    for (int i = 0; i < act_tx.size() && i < exp_tx.size(); i++) begin
      check_val("tx_load_cycle", act_tx[i].cyc_n, exp_tx[i].cyc_n);
      check_val("tx_word", act_tx[i].data, exp_tx[i].data);
    end
    check_val("wr_count", act_wr.size(), exp_wr.size());
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      check_val("wr_cycle", act_wr[i].cyc_n, exp_wr[i].cyc_n);
      check_val("wr_addr_data", act_wr[i].data, exp_wr[i].data);
    end
    check_val("rd_count", act_rd.size(), exp_rd.size());
    for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++) begin
      check_val("rd_cycle", act_rd[i].cyc_n, exp_rd[i].cyc_n);
      check_val("rd_addr", act_rd[i].data, exp_rd[i].data);
    end
    check_val("frame_error", frame_error, exp_err);
    check_val("frame_count", frame_count, exp_cnt);
    check_val("busy_idle", busy, 0);
    exp_tx.delete(); act_tx.delete();
    exp_wr.delete(); act_wr.delete();
    exp_rd.delete(); act_rd.delete();
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_rise = 1'($urandom_range(0, 1));
      if (i > 0) rx_word = $urandom;
      err_clear = 1'b0;
      step();
    end
    sclk_rise = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] word, input int nbits, input bit clr_before,
                           input bit clr_at_rise, output int rise_cyc);
    int stray;
    err_clear = 1'b0;
    if (clr_before) begin
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      exp_err   = 1'b0;
    end
    stray = $urandom_range(0, 2);
    for (int i = 0; i < stray; i++) begin
      sclk_rise = 1'b1;
      step();
    end
    sclk_rise = 1'b0;
    ss_n_sync = 1'b0;
    rx_word   = $urandom;
    step();
    check_val("busy_shift", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      sclk_rise = 1'b1;
      rx_word   = {rx_word[30:0], word[31 - (i % 32)]};
      step();
      sclk_rise = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
    end
    sclk_rise = 1'($urandom_range(0, 1));
    ss_n_sync = 1'b1;
    rx_word   = word;
    err_clear = clr_at_rise;
    rise_cyc  = cyc;
    if (clr_at_rise) exp_err = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ss_n_sync = 1'b1;
    sclk_rise = 1'b0;
    err_clear = 1'b0;
    step();
    reset = 1'b0;
    check_val("rst_tx_load", tx_load, 0);
    check_val("rst_tx_word", tx_word, 0);
    check_val("rst_wr_en", reg_bus.reg_wr_en, 0);
    check_val("rst_rd_en", reg_bus.reg_rd_en, 0);
    check_val("rst_addr", reg_bus.reg_addr, 0);
    check_val("rst_wdata", reg_bus.reg_wdata, 0);
    check_val("rst_frame_error", frame_error, 0);
    check_val("rst_frame_count", frame_count, 0);
    check_val("rst_busy", busy, 0);
    exp_cnt   = '0;
    exp_err   = 1'b0;
    valid_cyc = -1000;
    exp_tx.delete(); act_tx.delete();
    exp_wr.delete(); act_wr.delete();
    exp_rd.delete(); act_rd.delete();
  endtask

  initial begin
    int          rc;
    int          rc2;
    int          kind;
    int          nb;
    int          lat;
    logic [31:0] w;

    reset     = 1'b1;
    ss_n_sync = 1'b1;
    sclk_rise = 1'b0;
    err_clear = 1'b0;
    rx_word   = '0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Write, then a read answered three cycles after its strobe.
    rsp_lat = 0;
    run_frame(32'h8A123456, 32, 0, 0, rc);
    predict(32'h8A123456, 32, rc, 0, '0);
    settle(SETTLE);
    compare_all();

    rsp_lat  = 3;
    rsp_data = 24'hABCDEF;
    run_frame(32'h05000000, 32, 0, 0, rc);
    predict(32'h05000000, 32, rc, 3, rsp_data);
    settle(SETTLE);
    compare_all();

    // Short and long frames, then a lone clear, then clear colliding with an error.
    rsp_lat = 0;
    run_frame(32'h81000001, 31, 0, 0, rc);
    predict(32'h81000001, 31, rc, 0, '0);
    settle(SETTLE);
    compare_all();
    run_frame(32'h81000002, 33, 0, 0, rc);
    predict(32'h81000002, 33, rc, 0, '0);
    settle(SETTLE);
    compare_all();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    exp_err   = 1'b0;
    step();
    check_val("err_clear", frame_error, exp_err);
    run_frame(32'h81000003, 20, 0, 1, rc);
    predict(32'h81000003, 20, rc, 0, '0);
    settle(SETTLE);
    compare_all();

    // Read timeout and reserved bit.
    run_frame(32'h11000000, 32, 1, 0, rc);
    predict(32'h11000000, 32, rc, 0, '0);
    settle(SETTLE);
    compare_all();
    run_frame(32'h40000000, 32, 1, 0, rc);
    predict(32'h40000000, 32, rc, 0, '0);
    settle(SETTLE);
    compare_all();

    // New frame starts while a read is still waiting for data.
    run_frame(32'h0C000000, 32, 1, 0, rc);
    exp_rd.push_back(ev_t'{rc + 2, 32'h0000000C});
    settle(4);
    exp_err = 1'b1;
    run_frame(32'h9F00BEEF, 32, 0, 0, rc2);
    predict(32'h9F00BEEF, 32, rc2, 0, '0);
    settle(SETTLE);
    compare_all();

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 5);
      w    = $urandom;
      nb   = 32;
      lat  = 0;
      case (kind)
        0, 1: begin w[31] = 1'b1; w[30] = 1'b0; end
        2, 3: begin w[31] = 1'b0; w[30] = 1'b0; lat = $urandom_range(0, RD_TIMEOUT + 3); end
        4:    w[30] = 1'b1;
        default: begin
          nb = $urandom_range(0, 39);
          if (nb >= 32) nb++;
        end
      endcase
      rsp_lat  = lat;
      rsp_data = 24'($urandom);
      run_frame(w, nb, 1'($urandom_range(0, 1)), 1'b0, rc);
      predict(w, nb, rc, lat, rsp_data);
      settle(SETTLE);
      compare_all();
    end

    // Reset mid-SHIFT and mid-READ_WAIT.
    ss_n_sync = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      sclk_rise = 1'b1;
      step();
    end
    do_reset();
    rsp_lat = 0;
    run_frame(32'h03000000, 32, 0, 0, rc);
    settle(5);
    do_reset();

    // Counter wrap.
    force dut.frame_count_reg = 16'hFFFE;
    step();
    release dut.frame_count_reg;
    step();
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      w = {2'b10, 30'($urandom)};
      run_frame(w, 32, 0, 0, rc);
      predict(w, 32, rc, 0, '0);
      settle(SETTLE);
      compare_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
